// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA priority arbiter
//
// Holds the arbiter state enum, the default channel count and index width,
// and the bit positions of the arbiter-related command-register fields.

package dma_pkg;

    localparam int DMA_NUM_CH = 4;
    localparam int DMA_CH_W   = $clog2(DMA_NUM_CH);

    // Command-register bit positions consumed by the arbiter
    localparam int CMD_BIT_DREQ_SENSE_LOW     = 6;
    localparam int CMD_BIT_ROTATE_PRIORITY    = 4;
    localparam int CMD_BIT_CONTROLLER_DISABLE = 2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_GRANT   = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dma_priority_encoder.sv
// rtl/dma_priority_encoder.sv - circular first-set search over pending channels
//
// Purely combinational. Scans pending starting at start_idx and wrapping
// around; the first set bit found wins.
//   pending   in  NUM_CH  channels currently requesting service
//   start_idx in  CH_W    highest-priority channel for this search
//   winner    out CH_W    index of the chosen channel (0 when none)
//   valid     out 1       at least one channel is pending

module dma_priority_encoder #(
    parameter int  NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   start_idx,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    logic [CH_W-1:0] idx;

    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = |pending;
        // Walk from lowest to highest priority so the last hit, which is the
        // highest-priority pending channel, is the one that sticks.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = start_idx + CH_W'(i);
            if (pending[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - DMA channel request arbiter (HRQ/HLDA/DACK)
//
// Combines registered DREQ lines with the software request register, raises
// HRQ, picks a channel when HLDA returns and holds the grant until the
// timing-and-control block reports serviceDone.
// Optional feature macro: DMA_ROTATING_PRIORITY_EN (rotating priority and the
// lowPri register; without it priority is fixed, channel 0 highest).
//   CLK, RESET_N         clock, asynchronous active-low reset
//   DREQ                 external requests, polarity set by dreqSenseLow
//   dreqSenseLow         1 = DREQ active-low
//   rotatePriority       1 = rotating priority (only when compiled in)
//   controllerDisable    1 = accept no new requests
//   maskReg, requestReg  hardware request mask, software requests
//   HLDA, serviceDone    hold acknowledge, end-of-service pulse
//   HRQ, DACK            hold request, one-hot channel acknowledge
//   grantValid           a channel is granted
//   activeChannel        granted channel index, 0 when idle
//   swReqClr             one-cycle pulse clearing the serviced software request

module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int  NUM_CH = DMA_NUM_CH,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSenseLow,
    input  logic              rotatePriority,
    input  logic              controllerDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   activeChannel,
    output logic [NUM_CH-1:0] swReqClr
);

    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] dreq_q, dreq_d;
    logic [CH_W-1:0]   winner_q, winner_d;
    logic [NUM_CH-1:0] sw_req_clr_q, sw_req_clr_d;

    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   start_idx;
    logic [CH_W-1:0]   enc_winner;
    logic              enc_valid;
    logic              service_end;

    // Software requests bypass the mask.
    assign dreq_d  = DREQ;
    assign pending = ((dreq_q ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg;

    assign service_end = (state_q == ARB_GRANT) && serviceDone;

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CH_W-1:0] low_pri_q, low_pri_d;

    // Search begins one past the channel that was serviced last.
    assign start_idx = rotatePriority ? (low_pri_q + CH_W'(1)) : '0;

    always_comb begin
        low_pri_d = low_pri_q;
        if (service_end) begin
            low_pri_d = winner_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            low_pri_q <= CH_W'(NUM_CH - 1);
        end else begin
            low_pri_q <= low_pri_d;
        end
    end
`else
    logic unused_rotate_priority;

    assign start_idx              = '0;
    assign unused_rotate_priority = rotatePriority;
`endif

    dma_priority_encoder #(
        .NUM_CH (NUM_CH)
    ) u_encoder (
        .pending   (pending),
        .start_idx (start_idx),
        .winner    (enc_winner),
        .valid     (enc_valid)
    );

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        sw_req_clr_d = '0;
        case (state_q)
            ARB_IDLE: begin
                if (enc_valid && !controllerDisable) begin
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (!enc_valid || controllerDisable) begin
                    state_d = ARB_IDLE;
                end else if (HLDA) begin
                    state_d  = ARB_GRANT;
                    winner_d = enc_winner;
                end
            end
            ARB_GRANT: begin
                // Requests, mask and disable are frozen out until service
                // ends; only serviceDone or a lost HLDA leave this state.
                if (serviceDone) begin
                    state_d = ARB_RELEASE;
                    if (requestReg[winner_q]) begin
                        sw_req_clr_d = NUM_CH'(1) << winner_q;
                    end
                end else if (!HLDA) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_RELEASE: begin
                if (!HLDA) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ARB_IDLE;
            dreq_q       <= '0;
            winner_q     <= '0;
            sw_req_clr_q <= '0;
        end else begin
            state_q      <= state_d;
            dreq_q       <= dreq_d;
            winner_q     <= winner_d;
            sw_req_clr_q <= sw_req_clr_d;
        end
    end

    // Outputs decode registered state only.
    assign HRQ           = (state_q == ARB_REQ) || (state_q == ARB_GRANT);
    assign grantValid    = (state_q == ARB_GRANT);
    assign DACK          = grantValid ? (NUM_CH'(1) << winner_q) : '0;
    assign activeChannel = grantValid ? winner_q : '0;
    assign swReqClr      = sw_req_clr_q;

endmodule
